// File: rtl/move_input_encoder_if.sv
// Button/move bus between the raw button pad logic, the status source and the play controller.
interface move_input_encoder_if;
  logic [1:0] game_status;
  logic [3:0] btn;
  logic [3:0] act;
  logic [7:0] move_cnt;

  modport master (
    output game_status,
    output btn,
    input  act,
    input  move_cnt
  );

  modport slave (
    input  game_status,
    input  btn,
    output act,
    output move_cnt
  );
endinterface

// File: rtl/move_input_encoder.sv
// Direction push-button encoder: sync, debounce, one strobe per press, move counter.
module move_input_encoder #(
  parameter int unsigned DB_LIMIT = 20000,
  parameter int unsigned CNT_W    = 15
) (
  input logic                 clk_d,
  input logic                 reset,
  move_input_encoder_if.slave bus
);

  localparam int unsigned NB = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_LIMIT - 1);
  localparam logic [1:0] GS_GAMING  = 2'b01;
  localparam logic [1:0] GS_INITIAL = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FIRE,
    ST_WAIT_REL
  } state_t;

  logic [NB-1:0]    s1;
  logic [NB-1:0]    s2;
  logic [NB-1:0]    stable;
  logic [CNT_W-1:0] cnt [NB];
  state_t           state;
  logic [NB-1:0]    act_q;
  logic [7:0]       move_cnt_q;
  logic             one_hot_c;
  logic             gaming_c;

  // Two-flop synchronizer for the asynchronous buttons.
  always_ff @(posedge clk_d) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.btn;
      s2 <= s1;
    end
  end

  for (genvar gi = 0; gi < NB; gi++) begin : g_db
    // Accept a new level only after it has persisted DB_LIMIT consecutive cycles.
    always_ff @(posedge clk_d) begin
      if (reset) begin
        cnt[gi]    <= '0;
        stable[gi] <= 1'b0;
      end else if (s2[gi] == stable[gi]) begin
        cnt[gi] <= '0;
      end else if (cnt[gi] == CNT_LAST) begin
        stable[gi] <= s2[gi];
        cnt[gi]    <= '0;
      end else begin
        cnt[gi] <= cnt[gi] + CNT_W'(1);
      end
    end
  end

  assign one_hot_c = (stable != '0) && ((stable & (stable - NB'(1))) == '0);
  assign gaming_c  = (bus.game_status == GS_GAMING);

  // Press/release FSM with registered strobe and saturating move counter.
  always_ff @(posedge clk_d) begin
    if (reset) begin
      state      <= ST_IDLE;
      act_q      <= '0;
      move_cnt_q <= '0;
    end else begin
      act_q <= '0;
      case (state)
        ST_IDLE: begin
          if (stable != '0) begin
            if (one_hot_c && gaming_c) begin
              state <= ST_FIRE;
              act_q <= stable;
              if (move_cnt_q != 8'hFF) begin
                move_cnt_q <= move_cnt_q + 8'd1;
              end
            end else begin
              // Chords and presses outside GAMING are swallowed until release.
              state <= ST_WAIT_REL;
            end
          end
        end
        ST_FIRE: begin
          state <= ST_WAIT_REL;
        end
        ST_WAIT_REL: begin
          if (stable == '0) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
      // Start-of-game clear overrides any increment above.
      if (bus.game_status == GS_INITIAL) begin
        move_cnt_q <= '0;
      end
    end
  end

  assign bus.act      = act_q;
  assign bus.move_cnt = move_cnt_q;

endmodule
